fmi_tile_loader: RTL and testbench
==================================

# fmi_tile_loader

Stream-to-RAM loader that fills the input feature-map tile RAM (FMI) from the DMA read stream ahead of the expansion stage. It accepts packed pixel words pixel-interleaved (channel fastest, then x, then y). Each word is unpacked into single pixels, and each pixel is written to FMI in channel-planar layout (`addr = f*FMI_N_CHAN + y*Tix + x`). Tile dimensions are set at run time, up to the compile-time maxima `Tix`/`Tiy`/`Tif`.

## Interface
Parameters:
- `PX_W`, default `ram_pkg::PX_W` (16): pixel width.
- `PX_PER_WORD`, default 4: pixels per DMA word.
- `WORD_W`, default `PX_W*PX_PER_WORD`: DMA word width.
- `ADDR_W`, default `$clog2(FMI_N_ELEM)`: FMI address width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: pulse that latches `cfg_*` and begins a tile; ignored unless IDLE.
- `cfg_nx` / `cfg_ny` / `cfg_nf`, in, `$clog2(T*+1)` each: tile width / height / channels; legal range 1..`Tix` / `Tiy` / `Tif`.
- `s_valid`, in, 1: DMA word valid.
- `s_data`, in, `WORD_W`: DMA word; lane 0 is in bits `[PX_W-1:0]` and is the earliest pixel.
- `s_last`, in, 1: marks the final word of the tile.
- `s_ready`, out, 1: loader accepts the word this cycle.
- `ram_we`, out, 1: FMI write enable.
- `ram_addr`, out, `ADDR_W`: FMI write address.
- `ram_wdata`, out, `PX_W`: FMI write data.
- `busy`, out, 1: high outside IDLE.
- `done`, out, 1: one-cycle pulse at tile completion.
- `err`, out, 1: sticky error flag, cleared by the next accepted `start`.

## Operation
- State machine:
  - **IDLE**: on `start`, go to **CHECK**.
  - **CHECK**: if any cfg is 0 or above its maximum, set `err` and go to **DONE**; otherwise go to **LOAD**.
  - **LOAD**: `s_ready`=1. On handshake, register the word, set `lane`=0, go to **UNPACK**.
  - **UNPACK**: write one pixel per cycle.
    - After the tile's final pixel, go to **DONE**.
    - After lane `PX_PER_WORD-1` with no new word, go to **LOAD**.
  - **DONE**: `done`=1 for one cycle, then go to **IDLE**.
- Counters `f`, `x`, `y` run in stream order. `f` increments first; `x` increments when `f` wraps at `cfg_nf-1`; `y` increments when `x` wraps at `cfg_nx-1`.
  - Total pixels = `cfg_nx*cfg_ny*cfg_nf`.
- Address is generated incrementally, with no multiplier:
  - `pix_base = y*Tix + x` and `ch_off = f*FMI_N_CHAN` are held in registers.
  - `ch_off` adds `FMI_N_CHAN` per pixel and resets to 0 on an `f` wrap, at which point `pix_base` increments.
  - On an `x` wrap, `pix_base = (y+1)*Tix`.
- Final word may be partial: lanes past the last pixel are dropped and produce no writes.
- `s_last` check:
  - `s_last`=1 on a word other than the final one sets `err`; loading continues.
  - `s_last`=0 on the final word also sets `err`.
- A `start` received while busy is ignored and does not change `err`.
- Reset asserted mid-tile: all state returns to IDLE immediately and no further writes occur. FMI contents are undefined for that tile.

## Timing
- Reset values: `s_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `busy`=0, `done`=0, `err`=0.
- `start` at edge 0 gives CHECK in cycle 1 and LOAD in cycle 2 (`s_ready`=1).
- A word accepted at edge k produces writes on `ram_we` in cycles k+1 .. k+`PX_PER_WORD`. Write outputs are registered.
- Back-to-back words:
  - `s_ready`=1 in UNPACK during the cycle that writes lane `PX_PER_WORD-1`, when more pixels remain.
  - A handshake in that cycle continues UNPACK with no bubble, sustaining 1 pixel/cycle.
- `done` is high in the cycle after the final `ram_we`.
- A cfg error gives `done` 2 cycles after `start`, with no writes.

## Structure
- `ram_pkg` gains:
  - `FMI_ADDR_W = $clog2(FMI_N_ELEM)`.
  - `PX_PER_WORD` constant.
  - `fmi_ld_state_t` enum (IDLE, CHECK, LOAD, UNPACK, DONE).
- Tile maxima are taken from `dma_pkg`.
- One sub-module, `fmi_addr_gen`: the f/x/y counters, incremental address, and last-pixel flag.
- Top level contains the FSM, word register/unpack, and `s_last` check.

## Test plan
All scenarios use `Tix`=`Tiy`=4, `Tif`=8, giving `FMI_N_CHAN`=16.
1. **Reset**: hold `rst_n`=0 with random inputs -> all outputs 0. Assert `rst_n`=0 mid-UNPACK -> `ram_we` is 0 in the next cycle and `busy`=0.
2. **Full-word tile**: nx=2, ny=2, nf=4, 4 words streamed back-to-back -> 16 writes on consecutive cycles.
   - Word 0 -> addrs 0, 16, 32, 48; word 1 -> 1, 17, 33, 49; word 2 -> 4, 20, 36, 52; word 3 -> 5, 21, 37, 53.
   - `done` 1 cycle after the last write; `err`=0.
3. **Partial word**: nx=1, ny=1, nf=3, one word with `s_last` -> writes to addrs 0, 16, 32 only; lane 3 dropped; `done` follows.
4. **Backpressure**: same cfg as scenario 2 with `s_valid` toggling 1-0-0-1 -> no writes between words; address/data sequence identical to scenario 2.
5. **Protocol errors**:
   - nx=2, ny=1, nf=4 with `s_last` on word 0 -> `err`=1 and both words still written.
   - `cfg_nf`=0 -> `err`=1, `done` at cycle 2, zero writes.
6. **Start while busy**: pulse `start` during UNPACK -> ignored, write sequence unchanged, exactly one `done`.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - tile geometry maxima shared by the DMA and loader blocks
// Tix/Tiy/Tif are the compile-time tile maxima; *_W are the widths of the
// run-time tile dimension fields (wide enough to hold the maximum itself).
package dma_pkg;

  localparam int Tix  = 4;
  localparam int Tiy  = 4;
  localparam int Tif  = 8;

  localparam int NX_W = $clog2(Tix + 1);
  localparam int NY_W = $clog2(Tiy + 1);
  localparam int NF_W = $clog2(Tif + 1);

endpackage

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - FMI RAM geometry, loader constants and loader state type
// FMI is channel-planar: one plane of FMI_N_CHAN pixels per input channel.
package ram_pkg;

  import dma_pkg::*;

  localparam int PX_W        = 16;
  localparam int FMI_N_CHAN  = Tix * Tiy;
  localparam int FMI_N_ELEM  = FMI_N_CHAN * Tif;
  localparam int FMI_ADDR_W  = $clog2(FMI_N_ELEM);
  localparam int PX_PER_WORD = 4;

  typedef enum logic [2:0] {
    FMI_LD_IDLE,
    FMI_LD_CHECK,
    FMI_LD_LOAD,
    FMI_LD_UNPACK,
    FMI_LD_DONE
  } fmi_ld_state_t;

endpackage

// File: rtl/fmi_addr_gen.sv
// rtl/fmi_addr_gen.sv - stream-order f/x/y counters with incremental FMI address
// Ports: init clears the counters for a new tile; step advances to the next
//        pixel in stream order (f fastest, then x, then y). addr is the FMI
//        address of the current pixel and last flags the tile's final pixel.
module fmi_addr_gen
  import dma_pkg::*;
  import ram_pkg::*;
#(
  parameter int ADDR_W = FMI_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic [NX_W-1:0]   cfg_nx,
  input  logic [NY_W-1:0]   cfg_ny,
  input  logic [NF_W-1:0]   cfg_nf,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [NF_W-1:0]   f_q, f_d;
  logic [NX_W-1:0]   x_q, x_d;
  logic [NY_W-1:0]   y_q, y_d;
  logic [ADDR_W-1:0] ch_off_q, ch_off_d;
  logic [ADDR_W-1:0] pix_base_q, pix_base_d;
  // y*Tix kept separately so an x wrap can jump to the next row start.
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              f_wrap, x_wrap, y_wrap;

  assign f_wrap = (f_q + NF_W'(1)) == cfg_nf;
  assign x_wrap = (x_q + NX_W'(1)) == cfg_nx;
  assign y_wrap = (y_q + NY_W'(1)) == cfg_ny;
  assign addr   = ch_off_q + pix_base_q;
  assign last   = f_wrap & x_wrap & y_wrap;

  always_comb begin
    f_d        = f_q;
    x_d        = x_q;
    y_d        = y_q;
    ch_off_d   = ch_off_q;
    pix_base_d = pix_base_q;
    row_base_d = row_base_q;
    if (init) begin
      f_d        = '0;
      x_d        = '0;
      y_d        = '0;
      ch_off_d   = '0;
      pix_base_d = '0;
      row_base_d = '0;
    end else if (step) begin
      if (!f_wrap) begin
        f_d      = f_q + NF_W'(1);
        ch_off_d = ch_off_q + ADDR_W'(FMI_N_CHAN);
      end else begin
        f_d      = '0;
        ch_off_d = '0;
        if (!x_wrap) begin
          x_d        = x_q + NX_W'(1);
          pix_base_d = pix_base_q + ADDR_W'(1);
        end else begin
          x_d        = '0;
          y_d        = y_q + NY_W'(1);
          row_base_d = row_base_q + ADDR_W'(Tix);
          pix_base_d = row_base_q + ADDR_W'(Tix);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      ch_off_q   <= '0;
      pix_base_q <= '0;
      row_base_q <= '0;
    end else begin
      f_q        <= f_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ch_off_q   <= ch_off_d;
      pix_base_q <= pix_base_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/fmi_tile_loader.sv
// rtl/fmi_tile_loader.sv - DMA word stream to channel-planar FMI tile RAM loader
// Ports: start/cfg_* begin a tile; s_valid/s_data/s_last/s_ready carry packed
//        pixel words; ram_we/ram_addr/ram_wdata are registered FMI writes;
//        busy/done/err report status (err is sticky until the next start).
module fmi_tile_loader
  import dma_pkg::*;
  import ram_pkg::*;
#(
  parameter int PX_W        = ram_pkg::PX_W,
  parameter int PX_PER_WORD = ram_pkg::PX_PER_WORD,
  parameter int WORD_W      = PX_W * PX_PER_WORD,
  parameter int ADDR_W      = ram_pkg::FMI_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NX_W-1:0]   cfg_nx,
  input  logic [NY_W-1:0]   cfg_ny,
  input  logic [NF_W-1:0]   cfg_nf,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PX_W-1:0]   ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LANE_W = (PX_PER_WORD > 1) ? $clog2(PX_PER_WORD) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PX_PER_WORD - 1);

  fmi_ld_state_t     state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_last_q, word_last_d;
  logic [LANE_W-1:0] lane_q, lane_d, lane_nxt;
  logic              err_q, err_d;
  logic [NX_W-1:0]   nx_q, nx_d;
  logic [NY_W-1:0]   ny_q, ny_d;
  logic [NF_W-1:0]   nf_q, nf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PX_W-1:0]   wdata_q, wdata_d;
  // Marks that the pixel currently on the write port is the tile's last one.
  logic              pix_last_q, pix_last_d;

  logic              gen_init, gen_step, gen_last, take, emit, cfg_bad;
  logic [ADDR_W-1:0] gen_addr;
  logic [PX_W-1:0]   px;

  fmi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (gen_init),
    .step   (gen_step),
    .cfg_nx (nx_q),
    .cfg_ny (ny_q),
    .cfg_nf (nf_q),
    .addr   (gen_addr),
    .last   (gen_last)
  );

  assign cfg_bad   = (nx_q == '0) || (nx_q > NX_W'(Tix)) ||
                     (ny_q == '0) || (ny_q > NY_W'(Tiy)) ||
                     (nf_q == '0) || (nf_q > NF_W'(Tif));
  assign busy      = (state_q != FMI_LD_IDLE);
  assign done      = (state_q == FMI_LD_DONE);
  assign err       = err_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  // Write outputs are loaded one edge ahead: the edge that accepts a word
  // already registers lane 0, so each UNPACK cycle shows one pixel.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    word_last_d = word_last_q;
    lane_d      = lane_q;
    err_d       = err_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    nf_d        = nf_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pix_last_d  = pix_last_q;
    gen_init    = 1'b0;
    gen_step    = 1'b0;
    s_ready     = 1'b0;
    take        = 1'b0;
    emit        = 1'b0;
    px          = '0;
    lane_nxt    = lane_q + LANE_W'(1);
    unique case (state_q)
      FMI_LD_IDLE: begin
        if (start) begin
          nx_d       = cfg_nx;
          ny_d       = cfg_ny;
          nf_d       = cfg_nf;
          err_d      = 1'b0;
          pix_last_d = 1'b0;
          gen_init   = 1'b1;
          state_d    = FMI_LD_CHECK;
        end
      end
      FMI_LD_CHECK: begin
        if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = FMI_LD_DONE;
        end else begin
          state_d = FMI_LD_LOAD;
        end
      end
      FMI_LD_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          take    = 1'b1;
          state_d = FMI_LD_UNPACK;
        end
      end
      FMI_LD_UNPACK: begin
        if (pix_last_q) begin
          // Final pixel is on the port: the word holding it must carry s_last.
          if (!word_last_q) err_d = 1'b1;
          state_d = FMI_LD_DONE;
        end else if (lane_q == LAST_LANE) begin
          // Word exhausted with pixels still to come: it was not the final word.
          if (word_last_q) err_d = 1'b1;
          s_ready = 1'b1;
          if (s_valid) take = 1'b1;
          else         state_d = FMI_LD_LOAD;
        end else begin
          emit   = 1'b1;
          px     = word_q[int'(lane_nxt)*PX_W +: PX_W];
          lane_d = lane_nxt;
        end
      end
      FMI_LD_DONE: state_d = FMI_LD_IDLE;
      default:     state_d = FMI_LD_IDLE;
    endcase
    if (take) begin
      word_d      = s_data;
      word_last_d = s_last;
      lane_d      = '0;
      emit        = 1'b1;
      px          = s_data[PX_W-1:0];
    end
    if (emit) begin
      we_d       = 1'b1;
      addr_d     = gen_addr;
      wdata_d    = px;
      pix_last_d = gen_last;
    end
    gen_step = emit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FMI_LD_IDLE;
      word_q      <= '0;
      word_last_q <= 1'b0;
      lane_q      <= '0;
      err_q       <= 1'b0;
      nx_q        <= '0;
      ny_q        <= '0;
      nf_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      word_last_q <= word_last_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      nf_q        <= nf_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pix_last_q  <= pix_last_d;
    end
  end

endmodule

// File: tb/tb_fmi_tile_loader.sv
// tb/tb_fmi_tile_loader.sv - directed self-checking bench for fmi_tile_loader
module tb_fmi_tile_loader;
  import dma_pkg::*;
  import ram_pkg::*;

  localparam int PW = 16;
  localparam int WW = 64;
  localparam int AW = FMI_ADDR_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NX_W-1:0] cfg_nx = '0;
  logic [NY_W-1:0] cfg_ny = '0;
  logic [NF_W-1:0] cfg_nf = '0;
  logic            s_valid = 1'b0;
  logic [WW-1:0]   s_data = '0;
  logic            s_last = 1'b0;
  logic            s_ready, ram_we, busy, done, err;
  logic [AW-1:0]   ram_addr;
  logic [PW-1:0]   ram_wdata;

  fmi_tile_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_nx(cfg_nx), .cfg_ny(cfg_ny), .cfg_nf(cfg_nf),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        wr_addr.push_back(int'(ram_addr));
        wr_data.push_back(int'(ram_wdata));
        wr_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_word(input int w);
    logic [WW-1:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[l*PW +: PW] = PW'(32'hA000 + w*4 + l);
    return r;
  endfunction

  task automatic send_tile(input int nx, input int ny, input int nf, input int nw,
                           input int gap, input int last_at, output int t0);
    bit got;
    int waitc;
    @(posedge clk); #1;
    cfg_nx = NX_W'(nx); cfg_ny = NY_W'(ny); cfg_nf = NF_W'(nf);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    for (int w = 0; w < nw; w++) begin
      if (w > 0 && gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = mk_word(w);
      s_last  = (w == last_at);
      got = 1'b0;
      waitc = 0;
      while (!got && waitc < 50) begin
        @(negedge clk);
        got = s_ready;
        @(posedge clk); #1;
        waitc++;
      end
      if (!got) check("s_ready_timeout", 0, 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic check_seq(input string tag, input int b, input int exp_a[$], input int exp_d[$]);
    check({tag, "_nwr"}, wr_addr.size() - b, exp_a.size());
    if (wr_addr.size() - b == exp_a.size()) begin
      for (int i = 0; i < exp_a.size(); i++) begin
        check($sformatf("%s_addr%0d", tag, i), wr_addr[b+i], exp_a[i]);
        check($sformatf("%s_data%0d", tag, i), wr_data[b+i], exp_d[i]);
      end
    end
  endtask

  int exp_a16[$] = '{0, 16, 32, 48, 1, 17, 33, 49, 4, 20, 36, 52, 5, 21, 37, 53};
  int exp_d16[$];
  int exp_a3[$]  = '{0, 16, 32};
  int exp_d3[$]  = '{32'hA000, 32'hA001, 32'hA002};
  int exp_a8[$]  = '{0, 16, 32, 48, 1, 17, 33, 49};
  int exp_d8[$];

  initial begin
    int b, d0, t0;
    for (int i = 0; i < 16; i++) exp_d16.push_back(32'hA000 + i);
    for (int i = 0; i < 8; i++)  exp_d8.push_back(32'hA000 + i);

    // 1. reset with random inputs
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'($urandom); s_valid = 1'($urandom); s_last = 1'($urandom);
      s_data = {$urandom, $urandom};
      cfg_nx = NX_W'($urandom); cfg_ny = NY_W'($urandom); cfg_nf = NF_W'($urandom);
    end
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    start = 0; s_valid = 0; s_last = 0; s_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1b. reset asserted mid-UNPACK
    send_tile(2, 2, 4, 1, 0, -1, t0);
    @(negedge clk);
    check("mid_we_before", ram_we, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b = wr_addr.size();
    repeat (5) @(posedge clk);
    check("mid_rst_nowrites", wr_addr.size() - b, 0);
    check("mid_rst_idle", busy, 0);

    // 2. full-word tile, back-to-back words
    b = wr_addr.size(); d0 = done_cnt;
    send_tile(2, 2, 4, 4, 0, 3, t0);
    wait_done(d0);
    check_seq("full", b, exp_a16, exp_d16);
    if (wr_addr.size() - b == 16) begin
      check("full_first_lat", wr_cyc[b], t0 + 2);
      check("full_consecutive", wr_cyc[b+15] - wr_cyc[b], 15);
      check("full_done_time", done_cyc, wr_cyc[b+15] + 1);
    end
    check("full_done_cnt", done_cnt - d0, 1);
    check("full_err", err, 0);
    check("full_idle", busy, 0);

    // 3. partial final word
    b = wr_addr.size(); d0 = done_cnt;
    send_tile(1, 1, 3, 1, 0, 0, t0);
    wait_done(d0);
    check_seq("part", b, exp_a3, exp_d3);
    if (wr_addr.size() - b == 3) check("part_done_time", done_cyc, wr_cyc[b+2] + 1);
    check("part_done_cnt", done_cnt - d0, 1);
    check("part_err", err, 0);

    // 4. backpressure between words
    b = wr_addr.size(); d0 = done_cnt;
    send_tile(2, 2, 4, 4, 6, 3, t0);
    wait_done(d0);
    check_seq("bp", b, exp_a16, exp_d16);
    if (wr_addr.size() - b == 16) check("bp_gaps", (wr_cyc[b+15] - wr_cyc[b]) > 15, 1);
    check("bp_done_cnt", done_cnt - d0, 1);
    check("bp_err", err, 0);

    // 5a. s_last on a non-final word
    b = wr_addr.size(); d0 = done_cnt;
    send_tile(2, 1, 4, 2, 0, 0, t0);
    wait_done(d0);
    check_seq("early_last", b, exp_a8, exp_d8);
    check("early_last_err", err, 1);

    // 5b. illegal cfg: nf = 0
    b = wr_addr.size(); d0 = done_cnt;
    send_tile(2, 2, 0, 0, 0, -1, t0);
    wait_done(d0);
    check("cfg0_err", err, 1);
    check("cfg0_done_time", done_cyc, t0 + 1);
    check("cfg0_nwr", wr_addr.size() - b, 0);
    check("cfg0_done_cnt", done_cnt - d0, 1);

    // 6. start pulse while busy is ignored
    b = wr_addr.size(); d0 = done_cnt;
    fork
      send_tile(2, 2, 4, 4, 0, 3, t0);
      begin
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; cfg_nf = '0;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done(d0);
    check_seq("busy_start", b, exp_a16, exp_d16);
    check("busy_start_done_cnt", done_cnt - d0, 1);
    check("busy_start_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
